ps2_packet_ctrl: RTL and testbench

PS2_PACKET_CTRL -- requirements
Module: ps2_packet_ctrl

---
 rtl/ps2_packet_ctrl.sv | 129 ++++++++++++
 tb/tb_ps2_packet_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_packet_ctrl.sv
// PS/2 three-byte packet framer feeding a two-entry packet FIFO.
// Drops completed packets when the FIFO is full and nothing is popped on that edge.
module ps2_packet_ctrl #(
    parameter int unsigned SYNC_BIT = 3,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_bytes,
    output logic        done,
    output logic        drop,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam logic [7:0] TLim = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StSearch, StB2, StB3} state_e;

    state_e      state_q, state_d;
    logic [7:0]  byte1_q, byte1_d, byte2_q, byte2_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [23:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]  count_q, count_d;
    logic        done_q, done_d, drop_q, drop_d;
    logic [7:0]  dcnt_q, dcnt_d;
    logic        push, pop, accept;
    logic [23:0] pkt;

    assign pkt = {byte1_q, byte2_q, in};

    always_comb begin
        state_d = state_q;
        byte1_d = byte1_q;
        byte2_d = byte2_q;
        tcnt_d  = tcnt_q;
        push    = 1'b0;
        if (in_valid) begin
            tcnt_d = '0;
            case (state_q)
                StSearch: begin
                    if (in[SYNC_BIT]) begin
                        byte1_d = in;
                        state_d = StB2;
                    end
                end
                StB2: begin
                    byte2_d = in;
                    state_d = StB3;
                end
                StB3: begin
                    push    = 1'b1;
                    state_d = StSearch;
                end
                default: state_d = StSearch;
            endcase
        end else if (state_q != StSearch) begin
            // The idle cycle that reaches TIMEOUT abandons the partial packet.
            if (tcnt_q >= TLim) begin
                state_d = StSearch;
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        pop     = (count_q != 2'd0) && out_ready;
        accept  = push && ((count_q != 2'd2) || pop);
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (pop) begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
        end
        // Write position depends on occupancy after any same-edge pop.
        if (accept) begin
            if (count_d == 2'd0) begin
                ent0_d = pkt;
            end else begin
                ent1_d = pkt;
            end
            count_d = count_d + 2'd1;
        end
        done_d = accept;
        drop_d = push && !accept;
        dcnt_d = (drop_d && (dcnt_q != 8'hff)) ? dcnt_q + 8'd1 : dcnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StSearch;
            byte1_q <= '0;
            byte2_q <= '0;
            tcnt_q  <= '0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            byte1_q <= byte1_d;
            byte2_q <= byte2_d;
            tcnt_q  <= tcnt_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_bytes = out_valid ? ent0_q : 24'h0;
    assign done      = done_q;
    assign drop      = drop_q;
    assign drop_cnt  = dcnt_q;
    assign busy      = (state_q != StSearch);

endmodule

// File: tb/tb_ps2_packet_ctrl.sv
// Bench for ps2_packet_ctrl: directed scenarios then random traffic, all checked
// every cycle against a queue-based packet model.
module tb_ps2_packet_ctrl;

    localparam int SYNC_BIT = 3;
    localparam int TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [23:0] out_bytes;
    logic        done;
    logic        drop;
    logic [7:0]  drop_cnt;
    logic        busy;

    ps2_packet_ctrl #(
        .SYNC_BIT (SYNC_BIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in        (in_byte),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bytes (out_bytes),
        .done      (done),
        .drop      (drop),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the packet being assembled, idle count, queued packets.
    logic [7:0]  part[$];
    logic [23:0] fifo[$];
    int          idle;
    bit          e_done;
    bit          e_drop;
    int          e_cnt;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rn, input bit v, input logic [7:0] b, input bit rdy);
        bit          completed;
        bit          pop;
        logic [23:0] pkt;
        completed = 1'b0;
        pkt       = 24'h0;
        e_done    = 1'b0;
        e_drop    = 1'b0;
        if (!rn) begin
            part.delete();
            fifo.delete();
            idle  = 0;
            e_cnt = 0;
            return;
        end
        pop = (fifo.size() > 0) && rdy;
        if (v) begin
            idle = 0;
            if (part.size() == 0) begin
                if (b[SYNC_BIT]) part.push_back(b);
            end else if (part.size() == 1) begin
                part.push_back(b);
            end else begin
                pkt       = {part[0], part[1], b};
                completed = 1'b1;
                part.delete();
            end
        end else if (part.size() > 0) begin
            idle++;
            if (idle >= TIMEOUT) begin
                part.delete();
                idle = 0;
            end
        end
        if (pop) void'(fifo.pop_front());
        if (completed) begin
            if (fifo.size() < 2) begin
                fifo.push_back(pkt);
                e_done = 1'b1;
            end else begin
                e_drop = 1'b1;
                if (e_cnt < 255) e_cnt++;
            end
        end
    endtask

    task automatic check_all();
        logic [23:0] eb;
        eb = (fifo.size() > 0) ? fifo[0] : 24'h0;
        chk("out_valid", 24'(out_valid), 24'(fifo.size() > 0));
        chk("out_bytes", out_bytes, eb);
        chk("done", 24'(done), 24'(e_done));
        chk("drop", 24'(drop), 24'(e_drop));
        chk("drop_cnt", 24'(drop_cnt), 24'(e_cnt));
        chk("busy", 24'(busy), 24'(part.size() > 0));
    endtask

    task automatic cycle(input bit rn, input bit v, input logic [7:0] b, input bit rdy);
        reset     = rn;
        in_valid  = v;
        in_byte   = b;
        out_ready = rdy;
        @(posedge clk);
        model(rn, v, b, rdy);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        cycle(1'b1, 1'b1, b, rdy);
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 8'h00, rdy);
    endtask

    initial begin
        idle  = 0;
        e_cnt = 0;
        cycle(1'b0, 1'b1, 8'h08, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_out_valid", 24'(out_valid), 24'h0);
        chk("rst_busy", 24'(busy), 24'h0);

        // Leading non-sync byte is skipped.
        send(8'h00, 1'b1); send(8'h08, 1'b1); send(8'h11, 1'b1); send(8'h22, 1'b1);
        chk("first_pkt", out_bytes, 24'h081122);
        chk("first_done", 24'(done), 24'h1);
        idle_cycles(2, 1'b1);

        // Sync bit ignored in byte2/byte3 positions.
        send(8'h08, 1'b0); send(8'h08, 1'b0); send(8'h08, 1'b0);
        send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        chk("order_head", out_bytes, 24'h080808);
        idle_cycles(1, 1'b1);
        chk("order_second", out_bytes, 24'h080000);
        idle_cycles(2, 1'b1);

        // Overflow: third packet dropped, then full FIFO with simultaneous pop.
        send(8'h08, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
        send(8'h08, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h08, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
        chk("ovf_drop", 24'(drop), 24'h1);
        chk("ovf_cnt", 24'(drop_cnt), 24'h1);
        chk("ovf_head", out_bytes, 24'h080102);
        send(8'h08, 1'b0); send(8'h07, 1'b0); send(8'h09, 1'b1);
        chk("full_pop_done", 24'(done), 24'h1);
        chk("full_pop_head", out_bytes, 24'h080304);
        idle_cycles(3, 1'b1);

        // Timeout exactly at TIMEOUT idle cycles, and one cycle short of it.
        send(8'h08, 1'b1); send(8'h33, 1'b1);
        idle_cycles(TIMEOUT, 1'b1);
        chk("timeout_busy", 24'(busy), 24'h0);
        send(8'h44, 1'b1);
        chk("timeout_nodone", 24'(done), 24'h0);
        send(8'h08, 1'b1); send(8'h33, 1'b1);
        idle_cycles(TIMEOUT - 1, 1'b1);
        send(8'h44, 1'b1);
        chk("pre_timeout_pkt", out_bytes, 24'h083344);
        idle_cycles(1, 1'b1);

        // Reset mid-packet and with a queued packet.
        send(8'h08, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
        send(8'h08, 1'b0); send(8'h11, 1'b0);
        cycle(1'b0, 1'b1, 8'h22, 1'b1);
        chk("midrst_valid", 24'(out_valid), 24'h0);
        send(8'h08, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
        chk("post_rst_pkt", out_bytes, 24'h080102);
        idle_cycles(1, 1'b1);

        // drop_cnt saturation.
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int p = 0; p < 260; p++) begin
            send(8'h08, 1'b0); send(8'(p), 1'b0); send(8'h5a, 1'b0);
        end
        chk("drop_sat", 24'(drop_cnt), 24'hff);

        // Random traffic with alternating dense and sparse byte phases.
        for (int i = 0; i < 3000; i++) begin
            bit         dense;
            bit         v;
            bit         rn;
            bit         rdy;
            logic [7:0] b;
            dense = ((i / 64) % 2) == 0;
            v     = $urandom_range(0, 99) < (dense ? 85 : 8);
            b     = 8'($urandom);
            rdy   = $urandom_range(0, 99) < 45;
            rn    = $urandom_range(0, 399) != 0;
            cycle(rn, v, b, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
